// File: rtl/rs_pkg.sv
// rs_pkg: shared defaults, ALU opcode constants and CDB slice helpers for the reservation station
package rs_pkg;
    localparam int XLEN_DEF     = 32;
    localparam int ROB_BITS_DEF = 4;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    // low bit of channel c inside a flattened broadcast bus whose fields are w bits wide
    function automatic int cdb_lo(input int c, input int w);
        return c * w;
    endfunction
endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: picks the oldest ready entry from an age matrix
//   older     in  DEPTH x DEPTH  older[j][k]=1 means entry j was issued before entry k
//   ready     in  DEPTH          entries eligible for dispatch
//   grant     out DEPTH          one-hot oldest ready entry (zero when none)
//   idx       out RS_BITS        encoded index of grant
//   any_ready out 1              at least one entry is ready
module rs_age_select
    import rs_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int RS_BITS = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
    input  logic [DEPTH-1:0]            ready,
    output logic [DEPTH-1:0]            grant,
    output logic [RS_BITS-1:0]          idx,
    output logic                        any_ready
);
    assign any_ready = |ready;
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < DEPTH; j++)
                if (older[j][i] && ready[j]) grant[i] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++)
            if (grant[i]) idx = RS_BITS'(i);
    end
endmodule

// File: rtl/rs_station.sv
// rs_station: out-of-order ALU reservation station with CDB wakeup and registered dispatch stage
//   clk_in, rst_in (async active-low), rdy_in (stall), flush_in (sync clear)
//   issue_*     : decoder op offer, accepted when issue_valid_in && issue_ready_out
//   cdb_*_in    : NUM_CDB flattened result broadcasts used for wakeup and issue bypass
//   exe_*       : registered valid/ready packet to the ALU
//   count_out   : number of busy entries
module rs_station
    import rs_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int NUM_CDB  = 2,
    parameter int XLEN     = XLEN_DEF,
    parameter int ROB_BITS = ROB_BITS_DEF
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush_in,
    input  logic                         issue_valid_in,
    output logic                         issue_ready_out,
    input  logic [6:0]                   op_type_in,
    input  logic [2:0]                   op_in,
    input  logic                         op_add_in,
    input  logic [XLEN-1:0]              v1_in,
    input  logic [XLEN-1:0]              v2_in,
    input  logic                         dep1_in,
    input  logic                         dep2_in,
    input  logic [ROB_BITS-1:0]          q1_in,
    input  logic [ROB_BITS-1:0]          q2_in,
    input  logic [ROB_BITS-1:0]          rd_rob_in,
    input  logic [XLEN-1:0]              pc_in,
    input  logic [NUM_CDB-1:0]           cdb_valid_in,
    input  logic [NUM_CDB*ROB_BITS-1:0]  cdb_rob_in,
    input  logic [NUM_CDB*XLEN-1:0]      cdb_value_in,
    output logic                         exe_valid_out,
    input  logic                         exe_ready_in,
    output logic [6:0]                   exe_op_type_out,
    output logic [2:0]                   exe_op_out,
    output logic                         exe_op_add_out,
    output logic [XLEN-1:0]              exe_v1_out,
    output logic [XLEN-1:0]              exe_v2_out,
    output logic [ROB_BITS-1:0]          exe_rob_out,
    output logic [XLEN-1:0]              exe_pc_out,
    output logic [$clog2(DEPTH+1)-1:0]   count_out
);
    localparam int RS_BITS = $clog2(DEPTH);
    localparam int CW      = $clog2(DEPTH+1);

    logic [ROB_BITS-1:0] cdb_rob [NUM_CDB];
    logic [XLEN-1:0]     cdb_val [NUM_CDB];
    for (genvar c = 0; c < NUM_CDB; c++) begin : g_cdb
        assign cdb_rob[c] = cdb_rob_in[cdb_lo(c, ROB_BITS) +: ROB_BITS];
        assign cdb_val[c] = cdb_value_in[cdb_lo(c, XLEN) +: XLEN];
    end

    logic [DEPTH-1:0]            busy, dep1, dep2, op_add;
    logic [ROB_BITS-1:0]         q1 [DEPTH];
    logic [ROB_BITS-1:0]         q2 [DEPTH];
    logic [ROB_BITS-1:0]         rob [DEPTH];
    logic [XLEN-1:0]             v1 [DEPTH];
    logic [XLEN-1:0]             v2 [DEPTH];
    logic [XLEN-1:0]             pc [DEPTH];
    logic [6:0]                  op_type [DEPTH];
    logic [2:0]                  op [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] older;

    logic [DEPTH-1:0]   ready, grant;
    logic [RS_BITS-1:0] sel, slot;
    logic               any_ready, do_issue, do_disp, hit1, hit2;
    logic [XLEN-1:0]    in_v1, in_v2;

    assign ready           = busy & ~dep1 & ~dep2;
    assign issue_ready_out = count_out < CW'(DEPTH);
    assign do_issue        = issue_valid_in && issue_ready_out && rdy_in && !flush_in;
    assign do_disp         = rdy_in && !flush_in && any_ready && (!exe_valid_out || exe_ready_in);

    rs_age_select #(.DEPTH(DEPTH), .RS_BITS(RS_BITS)) u_sel (
        .older     (older),
        .ready     (ready),
        .grant     (grant),
        .idx       (sel),
        .any_ready (any_ready)
    );

    // free-slot search and issue-cycle bypass; descending scans let the lowest index win
    always_comb begin
        slot  = '0;
        hit1  = 1'b0;
        hit2  = 1'b0;
        in_v1 = v1_in;
        in_v2 = v2_in;
        for (int i = DEPTH-1; i >= 0; i--)
            if (!busy[i]) slot = RS_BITS'(i);
        for (int c = NUM_CDB-1; c >= 0; c--) begin
            if (dep1_in && cdb_valid_in[c] && cdb_rob[c] == q1_in) begin
                hit1  = 1'b1;
                in_v1 = cdb_val[c];
            end
            if (dep2_in && cdb_valid_in[c] && cdb_rob[c] == q2_in) begin
                hit2  = 1'b1;
                in_v2 = cdb_val[c];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy            <= '0;
            dep1            <= '0;
            dep2            <= '0;
            op_add          <= '0;
            older           <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q1[i]      <= '0;
                q2[i]      <= '0;
                rob[i]     <= '0;
                v1[i]      <= '0;
                v2[i]      <= '0;
                pc[i]      <= '0;
                op_type[i] <= '0;
                op[i]      <= '0;
            end
            exe_valid_out   <= 1'b0;
            exe_op_type_out <= '0;
            exe_op_out      <= '0;
            exe_op_add_out  <= 1'b0;
            exe_v1_out      <= '0;
            exe_v2_out      <= '0;
            exe_rob_out     <= '0;
            exe_pc_out      <= '0;
            count_out       <= '0;
        end else if (flush_in) begin
            busy          <= '0;
            older         <= '0;
            count_out     <= '0;
            exe_valid_out <= 1'b0;
        end else if (rdy_in) begin
            // wakeup: later (lower c) assignments override, so the lowest channel wins
            for (int e = 0; e < DEPTH; e++)
                for (int c = NUM_CDB-1; c >= 0; c--) begin
                    if (busy[e] && dep1[e] && cdb_valid_in[c] && cdb_rob[c] == q1[e]) begin
                        v1[e]   <= cdb_val[c];
                        dep1[e] <= 1'b0;
                    end
                    if (busy[e] && dep2[e] && cdb_valid_in[c] && cdb_rob[c] == q2[e]) begin
                        v2[e]   <= cdb_val[c];
                        dep2[e] <= 1'b0;
                    end
                end
            if (do_disp) begin
                busy            <= busy & ~grant;
                exe_valid_out   <= 1'b1;
                exe_op_type_out <= op_type[sel];
                exe_op_out      <= op[sel];
                exe_op_add_out  <= op_add[sel];
                exe_v1_out      <= v1[sel];
                exe_v2_out      <= v2[sel];
                exe_rob_out     <= rob[sel];
                exe_pc_out      <= pc[sel];
            end else if (exe_ready_in) begin
                exe_valid_out <= 1'b0;
            end
            if (do_issue) begin
                busy[slot]    <= 1'b1;
                dep1[slot]    <= dep1_in && !hit1;
                dep2[slot]    <= dep2_in && !hit2;
                v1[slot]      <= in_v1;
                v2[slot]      <= in_v2;
                q1[slot]      <= q1_in;
                q2[slot]      <= q2_in;
                rob[slot]     <= rd_rob_in;
                pc[slot]      <= pc_in;
                op_type[slot] <= op_type_in;
                op[slot]      <= op_in;
                op_add[slot]  <= op_add_in;
                // every currently busy entry is older than the new one; the new one is older than none
                for (int j = 0; j < DEPTH; j++) older[j][slot] <= busy[j];
                older[slot] <= '0;
            end
            count_out <= count_out + CW'(do_issue) - CW'(do_disp);
        end
    end
endmodule

// File: tb/tb_rs_station.sv
// tb_rs_station: directed scoreboard bench for rs_station
module tb_rs_station;
    import rs_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, issue_valid_in, issue_ready_out;
    logic [6:0]  op_type_in;
    logic [2:0]  op_in;
    logic        op_add_in;
    logic [31:0] v1_in, v2_in, pc_in;
    logic        dep1_in, dep2_in;
    logic [3:0]  q1_in, q2_in, rd_rob_in;
    logic [1:0]  cdb_valid_in;
    logic [7:0]  cdb_rob_in;
    logic [63:0] cdb_value_in;
    logic        exe_valid_out, exe_ready_in;
    logic [6:0]  exe_op_type_out;
    logic [2:0]  exe_op_out;
    logic        exe_op_add_out;
    logic [31:0] exe_v1_out, exe_v2_out, exe_pc_out;
    logic [3:0]  exe_rob_out;
    logic [2:0]  count_out;

    rs_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .issue_valid_in(issue_valid_in), .issue_ready_out(issue_ready_out),
        .op_type_in(op_type_in), .op_in(op_in), .op_add_in(op_add_in),
        .v1_in(v1_in), .v2_in(v2_in), .dep1_in(dep1_in), .dep2_in(dep2_in),
        .q1_in(q1_in), .q2_in(q2_in), .rd_rob_in(rd_rob_in), .pc_in(pc_in),
        .cdb_valid_in(cdb_valid_in), .cdb_rob_in(cdb_rob_in), .cdb_value_in(cdb_value_in),
        .exe_valid_out(exe_valid_out), .exe_ready_in(exe_ready_in),
        .exe_op_type_out(exe_op_type_out), .exe_op_out(exe_op_out), .exe_op_add_out(exe_op_add_out),
        .exe_v1_out(exe_v1_out), .exe_v2_out(exe_v2_out), .exe_rob_out(exe_rob_out),
        .exe_pc_out(exe_pc_out), .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [6:0]  op_type;
        logic [2:0]  op;
        logic        op_add;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [3:0]  rob;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t mon_a;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic exp_t mk(input logic [31:0] a, b, input logic [3:0] rd, input logic [31:0] p);
        return '{op_type: OP_ALU, op: rd[2:0], op_add: rd[0], v1: a, v2: b, rob: rd, pc: p};
    endfunction

    // monitor: every accepted dispatch must match the head of the expected queue
    always @(negedge clk_in) begin
        if (rst_in && exe_valid_out && exe_ready_in) begin
            vectors++;
            mon_a = '{op_type: exe_op_type_out, op: exe_op_out, op_add: exe_op_add_out,
                      v1: exe_v1_out, v2: exe_v2_out, rob: exe_rob_out, pc: exe_pc_out};
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL dispatch: got rob=%0d v1=0x%0h with nothing expected", exe_rob_out, exe_v1_out);
            end else begin
                mon_e = sb.pop_front();
                if (mon_a !== mon_e) begin
                    miscompares++;
                    $display("FAIL dispatch: got rob=%0d v1=0x%0h v2=0x%0h pc=0x%0h, want rob=%0d v1=0x%0h v2=0x%0h pc=0x%0h",
                             mon_a.rob, mon_a.v1, mon_a.v2, mon_a.pc, mon_e.rob, mon_e.v1, mon_e.v2, mon_e.pc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        issue_valid_in = 1'b0;
        cdb_valid_in   = '0;
        flush_in       = 1'b0;
    endtask

    task automatic put(input logic [31:0] a, b, input logic d1, d2, input logic [3:0] t1, t2, rd,
                       input logic [31:0] p);
        issue_valid_in = 1'b1;
        op_type_in = OP_ALU;
        op_in      = rd[2:0];
        op_add_in  = rd[0];
        v1_in      = a;
        v2_in      = b;
        dep1_in    = d1;
        dep2_in    = d2;
        q1_in      = t1;
        q2_in      = t2;
        rd_rob_in  = rd;
        pc_in      = p;
    endtask

    task automatic cdb(input logic [1:0] m, input logic [3:0] r0, r1, input logic [31:0] d0, d1);
        cdb_valid_in = m;
        cdb_rob_in   = {r1, r0};
        cdb_value_in = {d1, d0};
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d packets outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish within bound");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; issue_valid_in = 1'b0; exe_ready_in = 1'b0;
        op_type_in = '0; op_in = '0; op_add_in = 1'b0; v1_in = '0; v2_in = '0; pc_in = '0;
        dep1_in = 1'b0; dep2_in = 1'b0; q1_in = '0; q2_in = '0; rd_rob_in = '0;
        cdb_valid_in = '0; cdb_rob_in = '0; cdb_value_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_valid", 32'(exe_valid_out), 0);
        chk("reset_count", 32'(count_out), 0);
        chk("reset_ready", 32'(issue_ready_out), 1);
        chk("reset_v1", exe_v1_out, 0);
        rst_in = 1'b1;

        // flush with three busy entries and a held packet
        for (int i = 0; i < 4; i++) begin
            put(32'h10 + 32'(i), 32'h0, 0, 0, 0, 0, 4'(i), 32'h200 + 32'(4*i));
            step();
        end
        chk("pre_flush_count", 32'(count_out), 3);
        chk("pre_flush_valid", 32'(exe_valid_out), 1);
        flush_in = 1'b1;
        put(32'h99, 32'h0, 0, 0, 0, 0, 4'd9, 32'h0);
        step();
        chk("flush_count", 32'(count_out), 0);
        chk("flush_valid", 32'(exe_valid_out), 0);
        step();
        step();
        chk("post_flush_valid", 32'(exe_valid_out), 0);

        // asynchronous reset mid-run
        put(32'h77, 32'h0, 0, 0, 0, 0, 4'd2, 32'h0);
        step();
        step();
        chk("premid_valid", 32'(exe_valid_out), 1);
        put(32'h78, 32'h0, 0, 0, 0, 0, 4'd3, 32'h0);
        step();
        chk("premid_count", 32'(count_out), 1);
        rst_in = 1'b0;
        #1;
        chk("midrst_valid", 32'(exe_valid_out), 0);
        chk("midrst_count", 32'(count_out), 0);
        chk("midrst_v1", exe_v1_out, 0);
        chk("midrst_ready", 32'(issue_ready_out), 1);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;

        // basic no-dependency issue: N+2 latency
        exe_ready_in = 1'b1;
        sb.push_back(mk(32'd5, 32'd7, 4'd3, 32'h100));
        put(32'd5, 32'd7, 0, 0, 0, 0, 4'd3, 32'h100);
        step();
        chk("basic_n1_valid", 32'(exe_valid_out), 0);
        chk("basic_n1_count", 32'(count_out), 1);
        step();
        chk("basic_n2_valid", 32'(exe_valid_out), 1);
        chk("basic_n2_v1", exe_v1_out, 5);
        chk("basic_n2_rob", 32'(exe_rob_out), 3);
        chk("basic_n2_count", 32'(count_out), 0);
        step();
        chk("basic_n3_valid", 32'(exe_valid_out), 0);
        drain();

        // two-channel wakeup on consecutive cycles
        sb.push_back(mk(32'h11, 32'h22, 4'd5, 32'h300));
        put(32'hdead, 32'hbeef, 1, 1, 4'd4, 4'd9, 4'd5, 32'h300);
        step();
        cdb(2'b01, 4'd4, 4'd0, 32'h11, 32'h0);
        step();
        cdb(2'b10, 4'd0, 4'd9, 32'h0, 32'h22);
        step();
        chk("wake_m2_valid", 32'(exe_valid_out), 0);
        step();
        chk("wake_m3_valid", 32'(exe_valid_out), 1);
        drain();

        // issue-cycle bypass from channel 1; channel 0 carries the same tag but is not valid
        sb.push_back(mk(32'hAB, 32'h3, 4'd7, 32'h400));
        put(32'h0, 32'h3, 1, 0, 4'd6, 4'd0, 4'd7, 32'h400);
        cdb(2'b10, 4'd6, 4'd6, 32'hCC, 32'hAB);
        step();
        chk("bypass_n1_valid", 32'(exe_valid_out), 0);
        step();
        chk("bypass_n2_valid", 32'(exe_valid_out), 1);
        chk("bypass_v1", exe_v1_out, 32'hAB);
        drain();

        // both channels match one tag: lowest channel wins
        sb.push_back(mk(32'h9, 32'h55, 4'd8, 32'h500));
        put(32'h9, 32'h0, 0, 1, 4'd0, 4'd2, 4'd8, 32'h500);
        step();
        cdb(2'b11, 4'd2, 4'd2, 32'h55, 32'h66);
        step();
        drain();

        // age ordering: A then C dispatch, B stays pending
        sb.push_back(mk(32'h31, 32'hA, 4'd1, 32'h600));
        sb.push_back(mk(32'h33, 32'hC, 4'd3, 32'h608));
        put(32'h0, 32'hA, 1, 0, 4'd1, 4'd0, 4'd1, 32'h600);
        step();
        put(32'h0, 32'hB, 1, 0, 4'd2, 4'd0, 4'd2, 32'h604);
        step();
        put(32'h0, 32'hC, 1, 0, 4'd3, 4'd0, 4'd3, 32'h608);
        step();
        cdb(2'b11, 4'd3, 4'd1, 32'h33, 32'h31);
        step();
        step();
        step();
        step();
        chk("age_pending_count", 32'(count_out), 1);
        drain();
        flush_in = 1'b1;
        step();
        chk("age_flush_count", 32'(count_out), 0);

        // backpressure and full station
        exe_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(mk(32'h60 + 32'(i), 32'h70 + 32'(i), 4'(8 + i), 32'h700 + 32'(4*i)));
            put(32'h60 + 32'(i), 32'h70 + 32'(i), 0, 0, 0, 0, 4'(8 + i), 32'h700 + 32'(4*i));
            step();
        end
        chk("full_count", 32'(count_out), 4);
        chk("full_ready", 32'(issue_ready_out), 0);
        chk("full_valid", 32'(exe_valid_out), 1);
        chk("held_v1_a", exe_v1_out, sb[0].v1);
        put(32'hFFF, 32'h0, 0, 0, 0, 0, 4'd15, 32'h0);
        step();
        chk("full_reject_count", 32'(count_out), 4);
        chk("held_v1_b", exe_v1_out, sb[0].v1);
        chk("held_rob", 32'(exe_rob_out), 32'(sb[0].rob));
        exe_ready_in = 1'b1;
        put(32'hFFF, 32'h0, 0, 0, 0, 0, 4'd15, 32'h0);
        step();
        chk("full_disp_reject_count", 32'(count_out), 3);
        for (int i = 1; i < 5; i++) begin
            chk("stream_valid", 32'(exe_valid_out), 1);
            chk("stream_rob", 32'(exe_rob_out), 32'(8 + i));
            step();
        end
        chk("stream_end_valid", 32'(exe_valid_out), 0);
        chk("stream_end_count", 32'(count_out), 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
